// File: rtl/bounce_gen.sv
// Switch-bounce emulator: turns a clean level into a contact-bouncy one for debouncer tests.
// Define BOUNCE_GEN_FIXED_EN for periodic, fully deterministic glitch spacing.
module bounce_gen #(
  parameter int unsigned BOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W         = 20,
  parameter int unsigned MIN_HOLD      = 16,
  parameter int unsigned HOLD_W        = 6,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clean_in,
  output logic       bouncey_out,
  output logic       busy_out,
  output logic [7:0] toggle_count_out
);

  localparam int unsigned HOLD_MAX = MIN_HOLD - 1 + (1 << HOLD_W) - 1;
  localparam int unsigned HCW      = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [15:0] TAPS     = 16'hB400;

  typedef enum logic {IDLE, BOUNCE} state_t;

  state_t            state;
  logic              level;
  logic [15:0]       lfsr;
  logic [CNT_W-1:0]  window;
  logic [HCW-1:0]    hold;
  logic [HCW-1:0]    hold_reload;
  logic [HOLD_W-1:0] hold_ext;

  always_comb begin
`ifdef BOUNCE_GEN_FIXED_EN
    hold_ext = '0;
`else
    hold_ext = lfsr[HOLD_W-1:0];
`endif
    hold_reload = HCW'(MIN_HOLD - 1) + HCW'(hold_ext);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : '0);
    end
  end

  // A level change restarts the window from either state, so it is tested first.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      level            <= 1'b0;
      bouncey_out      <= 1'b0;
      busy_out         <= 1'b0;
      toggle_count_out <= '0;
      window           <= '0;
      hold             <= '0;
    end else if (clean_in != level) begin
      state            <= BOUNCE;
      level            <= clean_in;
      bouncey_out      <= clean_in;
      busy_out         <= 1'b1;
      toggle_count_out <= '0;
      window           <= CNT_W'(BOUNCE_CYCLES - 1);
      hold             <= hold_reload;
    end else if (state == BOUNCE) begin
      if (window == '0) begin
        state       <= IDLE;
        bouncey_out <= level;
        busy_out    <= 1'b0;
      end else begin
        window <= window - CNT_W'(1);
        if (hold == '0) begin
          bouncey_out <= ~bouncey_out;
          hold        <= hold_reload;
          if (toggle_count_out != 8'hFF) begin
            toggle_count_out <= toggle_count_out + 8'd1;
          end
        end else begin
          hold <= hold - HCW'(1);
        end
      end
    end
  end

endmodule
